// File: rtl/ifu_fetch_queue.sv
// Instruction fetch unit: up to MAX_OUTSTANDING sequential requests in flight, DEPTH-entry {pc, inst} queue.
// Define IFU_PERF_CNT_EN to add saturating fetch/drop/stall performance counters.
module ifu_fetch_queue #(
    parameter int unsigned       ADDR_W          = 32,
    parameter int unsigned       INST_W          = 32,
    parameter int unsigned       DEPTH           = 4,
    parameter int unsigned       MAX_OUTSTANDING = 2,
    parameter logic [ADDR_W-1:0] RESET_PC        = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              FORWARD_stallIF,
    input  logic              BRANCH_PCSrc,
    input  logic [ADDR_W-1:0] BRANCH_branch_target,
    output logic [INST_W-1:0] IFU_o_inst,
    output logic [ADDR_W-1:0] IFU_o_pc,
    output logic              IFU_o_valid,
    output logic [ADDR_W-1:0] ARBITER_IFU_pc,
    output logic              ARBITER_IFU_pc_valid,
    input  logic              ARBITER_IFU_pc_ready,
    input  logic [INST_W-1:0] ARBITER_IFU_inst,
    input  logic              ARBITER_IFU_inst_valid,
    output logic              ARBITER_IFU_inst_ready
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]       IFU_perf_fetch,
    output logic [31:0]       IFU_perf_drop,
    output logic [31:0]       IFU_perf_stall
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned FW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    // fetch_pc is the address the next newly presented request will carry
    logic [ADDR_W-1:0] fetch_pc, req_pc;
    logic              req_valid, inst_ready_q, pending_drop;
    logic [OW-1:0]     outstanding, drop_cnt;
    logic [ADDR_W-1:0] fl_pc [MAX_OUTSTANDING];
    logic [FW-1:0]     fl_wr, fl_rd;
    logic [ADDR_W-1:0] q_pc [DEPTH];
    logic [INST_W-1:0] q_inst [DEPTH];
    logic [PW-1:0]     q_head, q_tail;
    logic [CW-1:0]     count;

    logic              redirect, req_hs, resp_hs, enq, deq, issue_ok, load_req;
    logic              req_valid_nx, pending_drop_nx;
    logic [OW-1:0]     outstanding_nx, drop_cnt_nx;
    logic [CW-1:0]     count_nx;
    logic [ADDR_W-1:0] fetch_base, fetch_pc_nx, req_pc_nx;
    logic [31:0]       credit_sum;

    function automatic logic [FW-1:0] fl_next(input logic [FW-1:0] p);
        return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + FW'(1);
    endfunction

    always_comb begin
        redirect       = BRANCH_PCSrc;
        req_hs         = req_valid & ARBITER_IFU_pc_ready;
        resp_hs        = ARBITER_IFU_inst_valid & inst_ready_q;
        enq            = resp_hs & (drop_cnt == '0) & ~redirect;
        deq            = (count != '0) & ~FORWARD_stallIF & ~redirect;
        outstanding_nx = outstanding + OW'(req_hs) - OW'(resp_hs);
        count_nx       = redirect ? '0 : count + CW'(enq) - CW'(deq);
        credit_sum     = 32'(outstanding_nx) + 32'(count_nx);
        issue_ok       = (credit_sum < DEPTH) && (32'(outstanding_nx) < MAX_OUTSTANDING);
        load_req       = ~req_valid | req_hs;
        fetch_base     = redirect ? BRANCH_branch_target : fetch_pc;
        req_valid_nx   = req_valid;
        req_pc_nx      = req_pc;
        fetch_pc_nx    = fetch_base;
        // a presented request is never withdrawn; a new one is only loaded once the slot is free
        if (load_req) begin
            req_valid_nx = issue_ok;
            if (issue_ok) begin
                req_pc_nx   = fetch_base;
                fetch_pc_nx = fetch_base + ADDR_W'(4);
            end
        end
        if (redirect) begin
            drop_cnt_nx     = outstanding_nx;
            pending_drop_nx = req_valid & ~req_hs;
        end else begin
            drop_cnt_nx     = drop_cnt - OW'(resp_hs & (drop_cnt != '0)) + OW'(req_hs & pending_drop);
            pending_drop_nx = pending_drop & ~req_hs;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc     <= RESET_PC;
            req_pc       <= '0;
            req_valid    <= 1'b0;
            inst_ready_q <= 1'b0;
            pending_drop <= 1'b0;
            outstanding  <= '0;
            drop_cnt     <= '0;
            fl_wr        <= '0;
            fl_rd        <= '0;
            q_head       <= '0;
            q_tail       <= '0;
            count        <= '0;
        end else begin
            fetch_pc     <= fetch_pc_nx;
            req_pc       <= req_pc_nx;
            req_valid    <= req_valid_nx;
            inst_ready_q <= 1'b1;
            pending_drop <= pending_drop_nx;
            outstanding  <= outstanding_nx;
            drop_cnt     <= drop_cnt_nx;
            count        <= count_nx;
            if (req_hs)  fl_wr <= fl_next(fl_wr);
            if (resp_hs) fl_rd <= fl_next(fl_rd);
            if (redirect) begin
                q_head <= '0;
                q_tail <= '0;
            end else begin
                if (enq) q_tail <= q_tail + PW'(1);
                if (deq) q_head <= q_head + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_hs) fl_pc[fl_wr] <= req_pc;
        if (enq) begin
            q_pc[q_tail]   <= fl_pc[fl_rd];
            q_inst[q_tail] <= ARBITER_IFU_inst;
        end
    end

    assign IFU_o_valid            = (count != '0);
    assign IFU_o_pc               = IFU_o_valid ? q_pc[q_head] : '0;
    assign IFU_o_inst             = IFU_o_valid ? q_inst[q_head] : '0;
    assign ARBITER_IFU_pc         = req_pc;
    assign ARBITER_IFU_pc_valid   = req_valid;
    assign ARBITER_IFU_inst_ready = inst_ready_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(enq && !deq && count == CW'(DEPTH)));
    a_no_stray_resp: assert property (@(posedge clk) disable iff (!rst)
        !(resp_hs && outstanding == '0));

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            IFU_perf_fetch <= '0;
            IFU_perf_drop  <= '0;
            IFU_perf_stall <= '0;
        end else begin
            if (req_hs && IFU_perf_fetch != '1)           IFU_perf_fetch <= IFU_perf_fetch + 32'd1;
            if (resp_hs && !enq && IFU_perf_drop != '1)   IFU_perf_drop  <= IFU_perf_drop + 32'd1;
            if (IFU_o_valid && FORWARD_stallIF && IFU_perf_stall != '1)
                IFU_perf_stall <= IFU_perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Bench for ifu_fetch_queue: the bench plays the arbiter/memory and predicts the served stream
// from request epochs (a redirect kills everything accepted or pending before it).
module tb_ifu_fetch_queue;

    localparam int MAX = 2;
    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        FORWARD_stallIF = 1'b0;
    logic        BRANCH_PCSrc = 1'b0;
    logic [31:0] BRANCH_branch_target = '0;
    logic [31:0] IFU_o_inst, IFU_o_pc, ARBITER_IFU_pc;
    logic        IFU_o_valid, ARBITER_IFU_pc_valid, ARBITER_IFU_inst_ready;
    logic        ARBITER_IFU_pc_ready = 1'b0;
    logic [31:0] ARBITER_IFU_inst = '0;
    logic        ARBITER_IFU_inst_valid = 1'b0;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] IFU_perf_fetch, IFU_perf_drop, IFU_perf_stall;
`endif

    ifu_fetch_queue dut (
        .clk(clk), .rst(rst),
        .FORWARD_stallIF(FORWARD_stallIF),
        .BRANCH_PCSrc(BRANCH_PCSrc),
        .BRANCH_branch_target(BRANCH_branch_target),
        .IFU_o_inst(IFU_o_inst), .IFU_o_pc(IFU_o_pc), .IFU_o_valid(IFU_o_valid),
        .ARBITER_IFU_pc(ARBITER_IFU_pc),
        .ARBITER_IFU_pc_valid(ARBITER_IFU_pc_valid),
        .ARBITER_IFU_pc_ready(ARBITER_IFU_pc_ready),
        .ARBITER_IFU_inst(ARBITER_IFU_inst),
        .ARBITER_IFU_inst_valid(ARBITER_IFU_inst_valid),
        .ARBITER_IFU_inst_ready(ARBITER_IFU_inst_ready)
`ifdef IFU_PERF_CNT_EN
        ,
        .IFU_perf_fetch(IFU_perf_fetch),
        .IFU_perf_drop(IFU_perf_drop),
        .IFU_perf_stall(IFU_perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    typedef struct { logic [31:0] pc; bit live; } fl_t;

    ent_t mq[$];
    fl_t  fl[$];
    int   n_checks = 0, n_fail = 0;
    int   n_fetch = 0, n_drop = 0, n_stall = 0;
    int   p_ready = 100, p_resp = 100, p_stall = 0, p_redir = 0;
    bit   fix_tgt_en = 1'b0;
    logic [31:0] fix_tgt = '0;
    logic [31:0] exp_next = RESET_PC, prev_addr = '0;
    bit   prev_pending = 1'b0, pend_dead = 1'b0;
    logic last_o_valid, last_pcv, last_resp;
    logic [31:0] last_o_pc, last_req;

    function automatic logic [31:0] mem(logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        ent_t e;
        fl_t  f;
        bit   hs, resp, redir, push;
        logic [31:0] tgt;
        @(negedge clk);
        last_o_valid = IFU_o_valid; last_o_pc = IFU_o_pc;
        last_pcv = ARBITER_IFU_pc_valid; last_req = ARBITER_IFU_pc;
        chk("o_valid", 32'(IFU_o_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("o_pc", IFU_o_pc, mq[0].pc);
            chk("o_inst", IFU_o_inst, mq[0].inst);
        end else begin
            chk("o_pc_idle", IFU_o_pc, 32'h0);
            chk("o_inst_idle", IFU_o_inst, 32'h0);
        end
        chk("inst_ready", 32'(ARBITER_IFU_inst_ready), 32'd1);
        chk("outstanding_bound", 32'(fl.size() <= MAX), 32'd1);
        if (prev_pending) begin
            chk("req_no_withdraw", 32'(ARBITER_IFU_pc_valid), 32'd1);
            chk("req_hold", ARBITER_IFU_pc, prev_addr);
        end else if (ARBITER_IFU_pc_valid) begin
            chk("req_pc", ARBITER_IFU_pc, exp_next);
            exp_next = ARBITER_IFU_pc + 32'd4;
        end

        FORWARD_stallIF = ($urandom_range(99) < p_stall);
        redir = ($urandom_range(99) < p_redir);
        tgt = fix_tgt_en ? fix_tgt : ($urandom() & 32'hFFFF_FFFC);
        BRANCH_PCSrc = redir;
        BRANCH_branch_target = tgt;
        ARBITER_IFU_pc_ready = ($urandom_range(99) < p_ready);
        resp = (fl.size() != 0) && ($urandom_range(99) < p_resp);
        ARBITER_IFU_inst_valid = resp;
        ARBITER_IFU_inst = resp ? mem(fl[0].pc) : $urandom();
        hs = ARBITER_IFU_pc_valid && ARBITER_IFU_pc_ready;
        last_resp = resp;

        push = 1'b0;
        if (resp) begin
            f = fl.pop_front();
            if (f.live && !redir) begin
                e.pc = f.pc; e.inst = mem(f.pc); push = 1'b1;
            end else n_drop++;
        end
        if (mq.size() != 0 && !FORWARD_stallIF && !redir) mq.delete(0);
        if (push) mq.push_back(e);
        if (last_o_valid && FORWARD_stallIF) n_stall++;
        if (redir) begin
            mq.delete();
            foreach (fl[i]) fl[i].live = 1'b0;
            exp_next = tgt;
        end
        if (hs) begin
            f.pc = ARBITER_IFU_pc;
            f.live = !redir && !pend_dead;
            fl.push_back(f);
            n_fetch++;
        end
        if (redir) pend_dead = ARBITER_IFU_pc_valid && !hs;
        else if (hs) pend_dead = 1'b0;
        prev_pending = ARBITER_IFU_pc_valid && !hs;
        prev_addr = ARBITER_IFU_pc;
    endtask

    task automatic apply_reset(string tag);
        @(negedge clk);
        #2;
        rst = 1'b0;
        FORWARD_stallIF = 1'b0; BRANCH_PCSrc = 1'b0;
        ARBITER_IFU_pc_ready = 1'b0; ARBITER_IFU_inst_valid = 1'b0;
        #1;
        chk({tag, "_o_valid"}, 32'(IFU_o_valid), 32'd0);
        chk({tag, "_o_pc"}, IFU_o_pc, 32'h0);
        chk({tag, "_o_inst"}, IFU_o_inst, 32'h0);
        chk({tag, "_pc_valid"}, 32'(ARBITER_IFU_pc_valid), 32'd0);
        chk({tag, "_inst_ready"}, 32'(ARBITER_IFU_inst_ready), 32'd0);
        mq.delete(); fl.delete();
        exp_next = RESET_PC; prev_pending = 1'b0; pend_dead = 1'b0;
        n_fetch = 0; n_drop = 0; n_stall = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_valid(string tag, logic [31:0] exp_pc);
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            found = last_o_valid;
        end
        chk({tag, "_seen"}, 32'(found), 32'd1);
        chk({tag, "_pc"}, last_o_pc, exp_pc);
    endtask

    initial begin
        bit found;
        logic [31:0] held;
        apply_reset("reset");

        // stall from reset: queue fills to DEPTH, head pinned at RESET_PC
        p_ready = 100; p_resp = 100; p_stall = 100; p_redir = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (last_o_valid) chk("b_head", last_o_pc, RESET_PC);
        end
        chk("b_fill", 32'(mq.size()), 32'(DEPTH));
        chk("b_pc_valid_low", 32'(last_pcv), 32'd0);
        chk("b_none_outstanding", 32'(fl.size()), 32'd0);

        // free-running stream, no gaps after warm-up
        p_stall = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (i >= 6) begin
                chk("a_stream_valid", 32'(last_o_valid), 32'd1);
                chk("a_req_valid", 32'(last_pcv), 32'd1);
            end
        end

        // redirect with two responses outstanding
        p_resp = 0;
        for (int i = 0; i < 20 && fl.size() != MAX; i++) step();
        chk("c_two_outstanding", 32'(fl.size()), 32'd2);
        fix_tgt_en = 1'b1; fix_tgt = 32'h8000_1000; p_redir = 100;
        step();
        p_redir = 0; p_resp = 100;
        wait_valid("c_first", 32'h8000_1000);

        // redirect while a request is held unaccepted
        p_ready = 0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = last_pcv;
        end
        chk("d_pending_seen", 32'(found), 32'd1);
        held = last_req;
        fix_tgt = 32'h8000_2000; p_redir = 100;
        step();
        p_redir = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("d_hold", last_req, held);
        end
        p_ready = 100;
        wait_valid("d_first", 32'h8000_2000);

        // redirect coinciding with response and dequeue; target near the top to exercise wrap
        for (int i = 0; i < 6; i++) step();
        fix_tgt = 32'hFFFF_FFF8; p_redir = 100;
        step();
        chk("e_busy", 32'({last_o_valid, last_resp}), 32'd3);
        p_redir = 0;
        step();
        chk("e_flush", 32'(last_o_valid), 32'd0);
        for (int i = 0; i < 12; i++) step();

        // random traffic
        fix_tgt_en = 1'b0;
        p_ready = 70; p_resp = 60; p_stall = 30; p_redir = 6;
        for (int i = 0; i < 800; i++) step();

        // asynchronous reset mid-burst, then restart at RESET_PC
        p_ready = 100; p_resp = 100; p_stall = 0; p_redir = 0;
        for (int i = 0; i < 8; i++) step();
        apply_reset("midrst");
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            found = last_pcv;
        end
        chk("g_restart_seen", 32'(found), 32'd1);
        chk("g_restart_pc", last_req, RESET_PC);
        for (int i = 0; i < 20; i++) step();
        p_ready = 60; p_resp = 50; p_stall = 40; p_redir = 10;
        for (int i = 0; i < 200; i++) step();

`ifdef IFU_PERF_CNT_EN
        @(negedge clk);
        chk("perf_fetch", IFU_perf_fetch, 32'(n_fetch));
        chk("perf_drop", IFU_perf_drop, 32'(n_drop));
        chk("perf_stall", IFU_perf_stall, 32'(n_stall));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
